// File: rtl/buscaminas_pkg.sv
// Shared minesweeper definitions: board geometry, cell codes and generator states.
// Used by the board generator and by the game FSM that consumes the board.
package buscaminas_pkg;

    localparam int BOARD_DIM = 8;
    localparam int NUM_CELLS = BOARD_DIM * BOARD_DIM;

    typedef logic [3:0] cell_t;
    typedef logic [2:0] coord_t;

    localparam cell_t CELL_EMPTY  = 4'd0;
    localparam cell_t CELL_MARKED = 4'd10;
    localparam cell_t CELL_BOMB   = 4'd11;

    // Galois feedback mask applied when the shifted-out bit is 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        GEN_IDLE,
        GEN_PLACE,
        GEN_WRITE,
        GEN_DONE
    } gen_state_t;

endpackage

// File: rtl/buscaminas_board_gen_if.sv
// Control and board-write bundle between the init logic, the board generator
// and the board memory.
interface buscaminas_board_gen_if;
    import buscaminas_pkg::*;

    logic        start;
    logic [15:0] seed;
    logic        wr_en;
    coord_t      wr_x;
    coord_t      wr_y;
    cell_t       wr_data;
    logic        busy;
    logic        done;
    logic [63:0] bomb_map;

    modport master (
        input  start, seed,
        output wr_en, wr_x, wr_y, wr_data, busy, done, bomb_map
    );

    modport slave (
        output start, seed,
        input  wr_en, wr_x, wr_y, wr_data, busy, done, bomb_map
    );

endinterface

// File: rtl/buscaminas_adj_count.sv
// Counts the bombs among the in-bounds 8-neighbours of cell (x, y).
// Edge and corner cells simply have fewer neighbours; the board does not wrap.
module buscaminas_adj_count
    import buscaminas_pkg::*;
(
    input  logic [63:0] bomb_map,
    input  coord_t      x,
    input  coord_t      y,
    output cell_t       count
);

    always_comb begin
        count = '0;
        for (int dx = -1; dx <= 1; dx++) begin
            for (int dy = -1; dy <= 1; dy++) begin
                if (!(dx == 0 && dy == 0) &&
                    (int'(x) + dx >= 0) && (int'(x) + dx < BOARD_DIM) &&
                    (int'(y) + dy >= 0) && (int'(y) + dy < BOARD_DIM)) begin
                    count = count + {3'b000,
                        bomb_map[6'((int'(x) + dx) * BOARD_DIM + int'(y) + dy)]};
                end
            end
        end
    end

endmodule

// File: rtl/buscaminas_board_gen.sv
// Minesweeper board generator: places NUM_BOMBS distinct mines with an LFSR,
// then streams all 64 cell codes through a single registered write port.
module buscaminas_board_gen
    import buscaminas_pkg::*;
#(
    parameter int          NUM_BOMBS    = 10,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
)
(
    input  logic                          clk,
    input  logic                          rst,
    buscaminas_board_gen_if.master        bus
);

    if (NUM_BOMBS < 0 || NUM_BOMBS > 63) begin : g_bad_num_bombs
        $error("buscaminas_board_gen: NUM_BOMBS must be within 0..63");
    end

    gen_state_t  state, state_n;
    logic [15:0] lfsr, lfsr_n;
    logic [5:0]  placed, placed_n;
    logic [5:0]  idx, idx_n;
    logic [63:0] bomb_map, bomb_map_n;
    logic        wr_en, wr_en_n;
    coord_t      wr_x, wr_x_n;
    coord_t      wr_y, wr_y_n;
    cell_t       wr_data, wr_data_n;
    logic        busy, busy_n;
    logic        done, done_n;
    logic [5:0]  cand;
    cell_t       adj;

    assign cand = lfsr[5:0];

    buscaminas_adj_count u_adj (
        .bomb_map (bomb_map),
        .x        (idx[5:3]),
        .y        (idx[2:0]),
        .count    (adj)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= GEN_IDLE;
            lfsr     <= DEFAULT_SEED;
            placed   <= '0;
            idx      <= '0;
            bomb_map <= '0;
            wr_en    <= 1'b0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            lfsr     <= lfsr_n;
            placed   <= placed_n;
            idx      <= idx_n;
            bomb_map <= bomb_map_n;
            wr_en    <= wr_en_n;
            wr_x     <= wr_x_n;
            wr_y     <= wr_y_n;
            wr_data  <= wr_data_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // A start seen while the done pulse is still visible is treated as part of DONE
    always_comb begin
        state_n    = state;
        lfsr_n     = lfsr;
        placed_n   = placed;
        idx_n      = idx;
        bomb_map_n = bomb_map;
        wr_en_n    = 1'b0;
        wr_x_n     = wr_x;
        wr_y_n     = wr_y;
        wr_data_n  = wr_data;
        busy_n     = busy;
        done_n     = 1'b0;

        case (state)
            GEN_IDLE: begin
                if (bus.start && !done) begin
                    state_n    = GEN_PLACE;
                    bomb_map_n = '0;
                    placed_n   = '0;
                    idx_n      = '0;
                    lfsr_n     = (bus.seed == 16'h0000) ? DEFAULT_SEED : bus.seed;
                    busy_n     = 1'b1;
                end
            end
            GEN_PLACE: begin
                lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
                if (NUM_BOMBS == 0) begin
                    state_n = GEN_WRITE;
                end else begin
                    if (!bomb_map[cand]) begin
                        bomb_map_n[cand] = 1'b1;
                        placed_n         = placed + 6'd1;
                    end
                    if (placed_n == 6'(NUM_BOMBS)) begin
                        state_n = GEN_WRITE;
                    end
                end
            end
            GEN_WRITE: begin
                wr_en_n   = 1'b1;
                wr_x_n    = idx[5:3];
                wr_y_n    = idx[2:0];
                wr_data_n = bomb_map[idx] ? CELL_BOMB : adj;
                idx_n     = idx + 6'd1;
                if (idx == 6'd63) begin
                    state_n = GEN_DONE;
                end
            end
            GEN_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = GEN_IDLE;
            end
            default: begin
                state_n = GEN_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.wr_en    = wr_en;
    assign bus.wr_x     = wr_x;
    assign bus.wr_y     = wr_y;
    assign bus.wr_data  = wr_data;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.bomb_map = bomb_map;

endmodule

// File: tb/tb_buscaminas_board_gen.sv
// Directed and seeded-random checks of the board generator with one and ten bombs,
// against an independent placement model and hand-computed boards.
module tb_buscaminas_board_gen;
    import buscaminas_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    buscaminas_board_gen_if bus1 ();
    buscaminas_board_gen_if bus10 ();

    buscaminas_board_gen #(.NUM_BOMBS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    buscaminas_board_gen #(.NUM_BOMBS(10)) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (bus10)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    cell_t       got_data [64];
    int          hits [64];
    int          n_writes, order_err, first_wr, done_cyc, busy_err, extra_writes;
    logic        busy_at_done;
    logic [63:0] final_map;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic st, input logic [15:0] s);
        if (which == 1) begin
            bus1.start = st;
            bus1.seed  = s;
        end else begin
            bus10.start = st;
            bus10.seed  = s;
        end
    endtask

    task automatic sampleBus(input int which, output logic en, output coord_t x,
                             output coord_t y, output cell_t d, output logic bsy,
                             output logic dn, output logic [63:0] bm);
        if (which == 1) begin
            en = bus1.wr_en; x = bus1.wr_x; y = bus1.wr_y; d = bus1.wr_data;
            bsy = bus1.busy; dn = bus1.done; bm = bus1.bomb_map;
        end else begin
            en = bus10.wr_en; x = bus10.wr_x; y = bus10.wr_y; d = bus10.wr_data;
            bsy = bus10.busy; dn = bus10.done; bm = bus10.bomb_map;
        end
    endtask

    function automatic logic [63:0] modelMap(input logic [15:0] s, input int n,
                                             output int cycles);
        logic [15:0] l;
        logic [63:0] m;
        int          placed;
        l      = (s == 16'h0000) ? 16'hACE1 : s;
        m      = '0;
        placed = 0;
        cycles = (n == 0) ? 1 : 0;
        while (placed < n) begin
            cycles++;
            if (!m[l[5:0]]) begin
                m[l[5:0]] = 1'b1;
                placed++;
            end
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        end
        return m;
    endfunction

    function automatic cell_t modelCell(input logic [63:0] m, input int x, input int y);
        int c;
        c = 0;
        if (m[x * 8 + y]) return 4'd11;
        for (int dx = -1; dx <= 1; dx++)
            for (int dy = -1; dy <= 1; dy++)
                if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < 8 &&
                    y + dy >= 0 && y + dy < 8 && m[(x + dx) * 8 + y + dy])
                    c++;
        return 4'(c);
    endfunction

    // Start one run, optionally poke start while busy, and record every write seen
    task automatic runBoard(input int which, input logic [15:0] s, input bit poke);
        logic        en, bsy, dn;
        coord_t      x, y;
        cell_t       d;
        logic [63:0] bm;
        int          cyc;
        bit          finished;
        n_writes = 0; order_err = 0; first_wr = -1; done_cyc = -1;
        busy_err = 0; extra_writes = 0; busy_at_done = 1'b1;
        for (int i = 0; i < 64; i++) begin
            got_data[i] = 4'hF;
            hits[i]     = 0;
        end
        bm = '0;
        @(negedge clk);
        applyStimulus(which, 1'b1, s);
        cyc      = -1;
        finished = 1'b0;
        while (!finished && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            sampleBus(which, en, x, y, d, bsy, dn, bm);
            if (en) begin
                if ({x, y} != 6'(n_writes)) order_err++;
                got_data[{x, y}] = d;
                hits[{x, y}]++;
                if (first_wr < 0) first_wr = cyc;
                n_writes++;
            end
            if (dn) begin
                finished     = 1'b1;
                done_cyc     = cyc;
                busy_at_done = bsy;
            end else if (!bsy) begin
                busy_err++;
            end
            applyStimulus(which, poke && bsy && !dn && (cyc % 7 == 3), s);
        end
        applyStimulus(which, 1'b0, s);
        checkOutput("done reached", 64'(finished), 64'd1);
        final_map = bm;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            sampleBus(which, en, x, y, d, bsy, dn, bm);
            if (en) extra_writes++;
            if (bm !== final_map) extra_writes++;
        end
    endtask

    task automatic checkRun(input string tag, input logic [15:0] s, input int n);
        int          p, data_err, hit_err;
        logic [63:0] m;
        m        = modelMap(s, n, p);
        data_err = 0;
        hit_err  = 0;
        for (int i = 0; i < 64; i++) begin
            if (got_data[i] !== modelCell(m, i / 8, i % 8)) data_err++;
            if (hits[i] != 1) hit_err++;
        end
        checkOutput({tag, " bomb_map"}, final_map, m);
        checkOutput({tag, " popcount"}, 64'($countones(final_map)), 64'(n));
        checkOutput({tag, " writes"}, 64'(n_writes), 64'd64);
        checkOutput({tag, " order"}, 64'(order_err), 64'd0);
        checkOutput({tag, " once each"}, 64'(hit_err), 64'd0);
        checkOutput({tag, " cell data"}, 64'(data_err), 64'd0);
        checkOutput({tag, " first wr cycle"}, 64'(first_wr), 64'(p + 1));
        checkOutput({tag, " done cycle"}, 64'(done_cyc), 64'(p + 65));
        checkOutput({tag, " busy at done"}, 64'(busy_at_done), 64'd0);
        checkOutput({tag, " busy gaps"}, 64'(busy_err), 64'd0);
        checkOutput({tag, " after done"}, 64'(extra_writes), 64'd0);
    endtask

    initial begin
        logic        en, bsy, dn;
        coord_t      x, y;
        cell_t       d;
        logic [63:0] bm;
        logic [63:0] ones_mask;
        int          idle_err, wait_cyc;
        bit          hit20;

        applyStimulus(1, 1'b0, 16'h0000);
        applyStimulus(10, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        sampleBus(10, en, x, y, d, bsy, dn, bm);
        checkOutput("reset wr_en/busy/done", {61'd0, en, bsy, dn}, 64'd0);
        checkOutput("reset wr_x/wr_y/wr_data", {54'd0, x, y, d}, 64'd0);
        checkOutput("reset bomb_map", bm, 64'd0);
        rst = 1'b0;

        idle_err = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            sampleBus(1, en, x, y, d, bsy, dn, bm);
            if (en || bsy || dn || bm != 0) idle_err++;
            sampleBus(10, en, x, y, d, bsy, dn, bm);
            if (en || bsy || dn || bm != 0) idle_err++;
        end
        checkOutput("idle quiet", 64'(idle_err), 64'd0);

        // Single bomb at (1,1): its eight neighbours read 1, everything else 0
        runBoard(1, 16'h0009, 1'b0);
        checkOutput("s9 bomb_map", final_map, 64'h0000_0000_0000_0200);
        checkOutput("s9 first wr", 64'(first_wr), 64'd2);
        checkOutput("s9 done", 64'(done_cyc), 64'd66);
        ones_mask = 64'h0000_0000_0007_0507;
        for (int i = 0; i < 64; i++)
            checkOutput($sformatf("s9 cell %0d", i), 64'(got_data[i]),
                        (i == 9) ? 64'd11 : (ones_mask[i] ? 64'd1 : 64'd0));
        checkRun("s9", 16'h0009, 1);

        runBoard(1, 16'h003F, 1'b0);
        checkOutput("s3F cell(7,7)", 64'(got_data[63]), 64'd11);
        checkOutput("s3F cell(6,6)", 64'(got_data[54]), 64'd1);
        checkOutput("s3F cell(6,7)", 64'(got_data[55]), 64'd1);
        checkOutput("s3F cell(7,6)", 64'(got_data[62]), 64'd1);
        checkOutput("s3F cell(0,0)", 64'(got_data[0]), 64'd0);
        checkOutput("s3F writes", 64'(n_writes), 64'd64);

        runBoard(1, 16'h0000, 1'b0);
        checkOutput("seed0 bomb_map", final_map, 64'h0000_0002_0000_0000);
        checkOutput("seed0 cell(4,1)", 64'(got_data[33]), 64'd11);

        for (int r = 0; r < 200; r++) begin
            logic [15:0] s;
            s = 16'($urandom_range(1, 65535));
            runBoard(10, s, 1'b1);
            checkRun($sformatf("rand%0d", r), s, 10);
        end

        // Abort a run mid-write and confirm the block recovers cleanly
        @(negedge clk);
        applyStimulus(10, 1'b1, 16'h1234);
        @(negedge clk);
        applyStimulus(10, 1'b0, 16'h1234);
        hit20    = 1'b0;
        wait_cyc = 0;
        while (!hit20 && wait_cyc < 2000) begin
            @(negedge clk);
            wait_cyc++;
            sampleBus(10, en, x, y, d, bsy, dn, bm);
            if (en && {x, y} == 6'd20) hit20 = 1'b1;
        end
        checkOutput("reached idx 20", 64'(hit20), 64'd1);
        rst = 1'b1;
        #1;
        sampleBus(10, en, x, y, d, bsy, dn, bm);
        checkOutput("abort wr_en", 64'(en), 64'd0);
        checkOutput("abort busy", 64'(bsy), 64'd0);
        checkOutput("abort bomb_map", bm, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        runBoard(10, 16'h1234, 1'b0);
        checkRun("after abort", 16'h1234, 10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
